// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: CPU port, DMA port, memory macro side,
// plus status and debug observation signals.
//   cpu_*      : CPU request side (req/we/addr/wdata in, rdata/ack out)
//   dma_*      : DMA/loader request side, same meaning as cpu_*
//   mem_*      : memory macro side (en/we/addr/wdata out, rdata in)
//   owner/busy : current/last grant and transaction-in-flight flag
//   state_dbg  : arbiter FSM state (0 IDLE, 1 ACCESS, 2 RESP)
//   starve_dbg : consecutive CPU grants taken while DMA was waiting
// Handshake: a requester raises req with we/addr/wdata stable and holds
// them until it sees a one-cycle ack; it drops req at the edge where ack=1.
// Modport slave is the arbiter view, master is the requester/memory view.
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          owner;
  logic          busy;
  logic [1:0]    state_dbg;
  logic [3:0]    starve_dbg;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner, busy, state_dbg, starve_dbg
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner, busy, state_dbg, starve_dbg
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one unified memory between the multi-cycle CPU and a
// DMA/loader port. CPU has fixed priority; after MAX_WAIT consecutive CPU
// grants with dma_req pending, DMA wins the next arbitration. Each
// transaction: IDLE (arbitrate) -> ACCESS for MEM_LAT cycles with mem_en
// high -> RESP with a one-cycle ack to the owner -> IDLE.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mem_bus_arbiter_if.slave (CPU, DMA, memory, status, debug)
module mem_bus_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LAT  = 4'(MEM_LAT);
  localparam logic [3:0] WMAX = 4'(MAX_WAIT);

  state_t        state;
  logic [3:0]    cnt;
  logic [3:0]    starve_cnt;
  logic          dma_win;

  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          owner_q;
  logic          busy_q;
  logic          cpu_ack_q;
  logic          dma_ack_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dma_rdata_q;

  // DMA only wins when the CPU is quiet or has used up its allowance.
  assign dma_win = bus.dma_req && (!bus.cpu_req || (starve_cnt == WMAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      starve_cnt  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req || bus.dma_req) begin
            owner_q  <= dma_win;
            mem_en_q <= 1'b1;
            busy_q   <= 1'b1;
            cnt      <= 4'd1;
            state    <= ACCESS;
            if (dma_win) begin
              mem_we_q    <= bus.dma_we;
              mem_addr_q  <= bus.dma_addr;
              mem_wdata_q <= bus.dma_wdata;
              starve_cnt  <= '0;
            end else begin
              mem_we_q    <= bus.cpu_we;
              mem_addr_q  <= bus.cpu_addr;
              mem_wdata_q <= bus.cpu_wdata;
              // Count only CPU grants that actually made DMA wait.
              if (!bus.dma_req)
                starve_cnt <= '0;
              else if (starve_cnt != WMAX)
                starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end

        ACCESS: begin
          if (cnt < LAT) begin
            cnt <= cnt + 4'd1;
          end else begin
            // mem_rdata is valid in this last access cycle.
            if (!mem_we_q) begin
              if (owner_q) dma_rdata_q <= bus.mem_rdata;
              else         cpu_rdata_q <= bus.mem_rdata;
            end
            if (owner_q) dma_ack_q <= 1'b1;
            else         cpu_ack_q <= 1'b1;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            state    <= RESP;
          end
        end

        RESP: begin
          // Requests are ignored here; the requester drops req this edge.
          cpu_ack_q <= 1'b0;
          dma_ack_q <= 1'b0;
          busy_q    <= 1'b0;
          cnt       <= '0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.owner      = owner_q;
  assign bus.busy       = busy_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.dma_ack    = dma_ack_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.state_dbg  = state;
  assign bus.starve_dbg = starve_cnt;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. dut_a uses MEM_LAT=2, MAX_WAIT=4;
// dut_b uses MEM_LAT=1. Inputs change and outputs are sampled on the
// falling edge; cycle 0 is the cycle whose closing rising edge samples req.
module tb_mem_bus_arbiter;

  logic clk;
  logic rst;

  int n_checks;
  int n_pass;

  mem_bus_arbiter_if #(.AW(32), .DW(32)) bus_a ();
  mem_bus_arbiter_if #(.AW(32), .DW(32)) bus_b ();

  mem_bus_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .MAX_WAIT(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mem_bus_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_WAIT(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Memory model: fixed word at 0x10, otherwise address xor a tag.
  assign bus_a.mem_rdata = (bus_a.mem_addr == 32'h10) ? 32'hDEADBEEF
                                                      : (bus_a.mem_addr ^ 32'hCAFE0000);
  assign bus_b.mem_rdata = (bus_b.mem_addr == 32'h10) ? 32'hDEADBEEF
                                                      : (bus_b.mem_addr ^ 32'hCAFE0000);

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected grant pattern under continuous contention (0 CPU, 1 DMA).
  logic [31:0] exp_q[$];
  logic [31:0] exp_starve_q[$];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus_a.cpu_req = 0; bus_a.cpu_we = 0; bus_a.cpu_addr = '0; bus_a.cpu_wdata = '0;
    bus_a.dma_req = 0; bus_a.dma_we = 0; bus_a.dma_addr = '0; bus_a.dma_wdata = '0;
    bus_b.cpu_req = 0; bus_b.cpu_we = 0; bus_b.cpu_addr = '0; bus_b.cpu_wdata = '0;
    bus_b.dma_req = 0; bus_b.dma_we = 0; bus_b.dma_addr = '0; bus_b.dma_wdata = '0;

    // ---- reset state ----
    step();
    check_eq("rst_mem_en",  bus_a.mem_en, 0);
    check_eq("rst_cpu_ack", bus_a.cpu_ack, 0);
    check_eq("rst_dma_ack", bus_a.dma_ack, 0);
    check_eq("rst_owner",   bus_a.owner, 0);
    check_eq("rst_busy",    bus_a.busy, 0);
    check_eq("rst_state",   bus_a.state_dbg, 0);
    rst = 1'b0;
    step();

    // ---- CPU read 0x10 ----
    bus_a.cpu_req = 1; bus_a.cpu_we = 0; bus_a.cpu_addr = 32'h10;
    step();  // cycle 1
    check_eq("rd_c1_en",    bus_a.mem_en, 1);
    check_eq("rd_c1_addr",  bus_a.mem_addr, 32'h10);
    check_eq("rd_c1_we",    bus_a.mem_we, 0);
    check_eq("rd_c1_owner", bus_a.owner, 0);
    check_eq("rd_c1_busy",  bus_a.busy, 1);
    step();  // cycle 2
    check_eq("rd_c2_en",    bus_a.mem_en, 1);
    check_eq("rd_c2_ack",   bus_a.cpu_ack, 0);
    step();  // cycle 3
    check_eq("rd_c3_ack",   bus_a.cpu_ack, 1);
    check_eq("rd_c3_dack",  bus_a.dma_ack, 0);
    check_eq("rd_c3_en",    bus_a.mem_en, 0);
    check_eq("rd_c3_rdata", bus_a.cpu_rdata, 32'hDEADBEEF);
    bus_a.cpu_req = 0;
    step();  // cycle 4
    check_eq("rd_c4_ack",   bus_a.cpu_ack, 0);
    check_eq("rd_c4_busy",  bus_a.busy, 0);
    check_eq("rd_c4_hold",  bus_a.cpu_rdata, 32'hDEADBEEF);

    // ---- DMA write 0x40 ----
    bus_a.dma_req = 1; bus_a.dma_we = 1; bus_a.dma_addr = 32'h40; bus_a.dma_wdata = 32'h12345678;
    step();  // cycle 1
    check_eq("wr_c1_en",    bus_a.mem_en, 1);
    check_eq("wr_c1_we",    bus_a.mem_we, 1);
    check_eq("wr_c1_addr",  bus_a.mem_addr, 32'h40);
    check_eq("wr_c1_wdata", bus_a.mem_wdata, 32'h12345678);
    check_eq("wr_c1_owner", bus_a.owner, 1);
    step();  // cycle 2
    check_eq("wr_c2_we",    bus_a.mem_we, 1);
    check_eq("wr_c2_dack",  bus_a.dma_ack, 0);
    step();  // cycle 3
    check_eq("wr_c3_dack",  bus_a.dma_ack, 1);
    check_eq("wr_c3_cack",  bus_a.cpu_ack, 0);
    check_eq("wr_c3_we",    bus_a.mem_we, 0);
    check_eq("wr_c3_rdata", bus_a.dma_rdata, 0);
    check_eq("wr_c3_crd",   bus_a.cpu_rdata, 32'hDEADBEEF);
    bus_a.dma_req = 0; bus_a.dma_we = 0;
    step();

    // ---- continuous contention, MAX_WAIT=4 ----
    exp_q        = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    exp_starve_q = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    bus_a.cpu_req = 1; bus_a.cpu_addr = 32'h20;
    bus_a.dma_req = 1; bus_a.dma_addr = 32'h30;
    for (int g = 0; g < 10; g++) begin
      step();  // cycle 1 of grant g
      check_eq($sformatf("arb_owner_%0d", g), bus_a.owner, exp_q[g]);
      check_eq($sformatf("arb_starve_%0d", g), bus_a.starve_dbg, exp_starve_q[g]);
      step_n(2);  // cycle 3
      check_eq($sformatf("arb_cack_%0d", g), bus_a.cpu_ack, (exp_q[g] == 0) ? 1 : 0);
      check_eq($sformatf("arb_dack_%0d", g), bus_a.dma_ack, exp_q[g]);
      if (exp_q[g] == 0) check_eq($sformatf("arb_crd_%0d", g), bus_a.cpu_rdata, 32'hCAFE0020);
      else               check_eq($sformatf("arb_drd_%0d", g), bus_a.dma_rdata, 32'hCAFE0030);
      if (g == 9) begin
        bus_a.cpu_req = 0;
        bus_a.dma_req = 0;
      end
      step();  // cycle 4 (IDLE)
    end
    step();

    // ---- simultaneous requests, starve_cnt=0 ----
    bus_a.cpu_req = 1; bus_a.cpu_addr = 32'h10;
    bus_a.dma_req = 1; bus_a.dma_addr = 32'h30;
    step();  // cycle 1
    check_eq("sim_c1_owner", bus_a.owner, 0);
    step_n(2);  // cycle 3
    check_eq("sim_c3_cack", bus_a.cpu_ack, 1);
    check_eq("sim_c3_en",   bus_a.mem_en, 0);
    bus_a.cpu_req = 0;
    step();  // cycle 4 (IDLE)
    check_eq("sim_c4_en",   bus_a.mem_en, 0);
    step();  // cycle 5
    check_eq("sim_c5_owner", bus_a.owner, 1);
    check_eq("sim_c5_en",    bus_a.mem_en, 1);
    check_eq("sim_c5_addr",  bus_a.mem_addr, 32'h30);
    step_n(2);  // cycle 7
    check_eq("sim_c7_dack", bus_a.dma_ack, 1);
    bus_a.dma_req = 0;
    step();

    // ---- reset in ACCESS counter=1 ----
    bus_a.cpu_req = 1; bus_a.cpu_addr = 32'h10;
    step();  // cycle 1, counter=1
    check_eq("rsta_pre_en", bus_a.mem_en, 1);
    rst = 1'b1;
    #1;
    check_eq("rsta_en",    bus_a.mem_en, 0);
    check_eq("rsta_busy",  bus_a.busy, 0);
    check_eq("rsta_owner", bus_a.owner, 0);
    check_eq("rsta_rdata", bus_a.cpu_rdata, 0);
    check_eq("rsta_addr",  bus_a.mem_addr, 0);
    step();
    check_eq("rsta_ack",   bus_a.cpu_ack, 0);
    rst = 1'b0;   // req still held: this is cycle 0
    step();  // cycle 1
    check_eq("rstr_c1_en",  bus_a.mem_en, 1);
    step();  // cycle 2
    check_eq("rstr_c2_ack", bus_a.cpu_ack, 0);
    step();  // cycle 3
    check_eq("rstr_c3_ack", bus_a.cpu_ack, 1);
    check_eq("rstr_rdata",  bus_a.cpu_rdata, 32'hDEADBEEF);
    bus_a.cpu_req = 0;
    step();

    // ---- MEM_LAT=1 back-to-back CPU reads ----
    bus_b.cpu_req = 1; bus_b.cpu_addr = 32'h20;
    step();  // cycle 1
    check_eq("l1_c1_en",  bus_b.mem_en, 1);
    check_eq("l1_c1_ack", bus_b.cpu_ack, 0);
    step();  // cycle 2
    check_eq("l1_c2_en",  bus_b.mem_en, 0);
    check_eq("l1_c2_ack", bus_b.cpu_ack, 1);
    check_eq("l1_c2_rd",  bus_b.cpu_rdata, 32'hCAFE0020);
    step();  // cycle 3: IDLE, req still held
    check_eq("l1_c3_en",  bus_b.mem_en, 0);
    check_eq("l1_c3_ack", bus_b.cpu_ack, 0);
    step();  // cycle 4: second access
    check_eq("l1_c4_en",  bus_b.mem_en, 1);
    step();  // cycle 5
    check_eq("l1_c5_ack", bus_b.cpu_ack, 1);
    bus_b.cpu_req = 0;
    step();
    check_eq("l1_idle_busy", bus_b.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
